// File: rtl/seq_stream_pkg.sv
// Shared definitions for the exercise-2 stream decoder: output codes of the
// transmitting state machine, decoder states and the transition table lookup.
package seq_stream_pkg;

    // Codes the transmitting machine is able to produce
    localparam logic [2:0] C0 = 3'd0;
    localparam logic [2:0] C2 = 3'd2;
    localparam logic [2:0] C3 = 3'd3;
    localparam logic [2:0] C4 = 3'd4;
    localparam logic [2:0] C5 = 3'd5;

    // HUNT: searching for a run of legal transitions; LOCKED: tracking the stream
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } decState_e;

    // Result of looking up one observed transition
    typedef struct packed {
        logic legal;
        logic isBranch;
        logic bitVal;
    } transInfo_t;

    // True for any code the transmitter can emit
    function automatic logic codeIsLegal(input logic [2:0] code);
        return (code == C0) || (code == C2) || (code == C3) ||
               (code == C4) || (code == C5);
    endfunction

    // Classify prev->cur against the state diagram; branches out of 3 and 4
    // reveal the input bit that steered the transmitter
    function automatic transInfo_t legal_next(input logic [2:0] prev,
                                              input logic [2:0] cur);
        transInfo_t info;
        info = '{legal: 1'b0, isBranch: 1'b0, bitVal: 1'b0};
        case (prev)
            C0: begin
                if (cur == C3) info.legal = 1'b1;
            end
            C3: begin
                if (cur == C5) begin
                    info = '{legal: 1'b1, isBranch: 1'b1, bitVal: 1'b1};
                end else if (cur == C2) begin
                    info = '{legal: 1'b1, isBranch: 1'b1, bitVal: 1'b0};
                end
            end
            C5: begin
                if (cur == C2) info.legal = 1'b1;
            end
            C2: begin
                if (cur == C4) info.legal = 1'b1;
            end
            C4: begin
                if (cur == C3) begin
                    info = '{legal: 1'b1, isBranch: 1'b1, bitVal: 1'b1};
                end else if (cur == C0) begin
                    info = '{legal: 1'b1, isBranch: 1'b1, bitVal: 1'b0};
                end
            end
            default: begin
                info = '{legal: 1'b0, isBranch: 1'b0, bitVal: 1'b0};
            end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/seq_deser.sv
// Packs recovered bits LSB-first into words and presents each bit and each
// completed word as registered one-cycle pulses.
module seq_deser
    import seq_stream_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              bitValid_i,
    input  logic              bit_i,
    output logic              aOut_o,
    output logic              aValid_o,
    output logic [WORD_W-1:0] wordOut_o,
    output logic              wordValid_o
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wordValid_q, wordValid_d;
    logic              aOut_q, aOut_d;
    logic              aValid_q, aValid_d;

    // Drop each bit into its slot; the last slot publishes the whole word
    // together with that bit's pulse and restarts the index
    always_comb begin
        shift_d     = shift_q;
        idx_d       = idx_q;
        word_d      = word_q;
        wordValid_d = 1'b0;
        aOut_d      = aOut_q;
        aValid_d    = 1'b0;
        if (clear_i) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (bitValid_i) begin
            aOut_d          = bit_i;
            aValid_d        = 1'b1;
            shift_d[idx_q]  = bit_i;
            if (idx_q == LAST_IDX) begin
                word_d      = shift_d;
                wordValid_d = 1'b1;
                shift_d     = '0;
                idx_d       = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Register all packing state; reset discards any partial word
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            wordValid_q <= 1'b0;
            aOut_q      <= 1'b0;
            aValid_q    <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            wordValid_q <= wordValid_d;
            aOut_q      <= aOut_d;
            aValid_q    <= aValid_d;
        end
    end

    assign aOut_o      = aOut_q;
    assign aValid_o    = aValid_q;
    assign wordOut_o   = word_q;
    assign wordValid_o = wordValid_q;

endmodule

// File: rtl/seq_stream_decoder.sv
// Receive-side checker for the exercise-2 state machine: validates every
// observed transition, recovers the steering bit from branches, packs bits
// into words and flags/counts illegal activity once synchronised.
module seq_stream_decoder
    import seq_stream_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int LOCK_N = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [2:0]        s_in,
    output logic              locked,
    output logic              a_out,
    output logic              a_valid,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int LCNT_W = $clog2(LOCK_N + 1);
    localparam logic [LCNT_W-1:0] LOCK_TARGET = LCNT_W'(LOCK_N);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    decState_e         state_q, state_d;
    logic [2:0]        prevCode_q, prevCode_d;
    logic              prevValid_q, prevValid_d;
    logic [LCNT_W-1:0] lockCnt_q, lockCnt_d;
    logic [LCNT_W-1:0] lockCntInc;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  errCount_q, errCount_d;
    logic              bitValid;
    logic              bitVal;
    logic              deserClear;
    logic              curLegal;
    transInfo_t        trans;

    // Decide the next decoder state from the current sample: count legal
    // transitions while hunting, emit bits or report errors while locked
    always_comb begin
        state_d     = state_q;
        prevCode_d  = prevCode_q;
        prevValid_d = prevValid_q;
        lockCnt_d   = lockCnt_q;
        err_d       = 1'b0;
        errCount_d  = errCount_q;
        bitValid    = 1'b0;
        bitVal      = 1'b0;
        deserClear  = 1'b0;
        curLegal    = codeIsLegal(s_in);
        trans       = legal_next(prevCode_q, s_in);
        lockCntInc  = lockCnt_q + LCNT_W'(1);
        if (s_valid) begin
            case (state_q)
                HUNT: begin
                    if (!curLegal) begin
                        prevValid_d = 1'b0;
                        lockCnt_d   = '0;
                    end else begin
                        prevCode_d  = s_in;
                        prevValid_d = 1'b1;
                        if (prevValid_q && trans.legal) begin
                            if (lockCntInc == LOCK_TARGET) begin
                                state_d   = LOCKED;
                                lockCnt_d = '0;
                            end else begin
                                lockCnt_d = lockCntInc;
                            end
                        end else begin
                            lockCnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (prevValid_q && trans.legal) begin
                        prevCode_d = s_in;
                        if (trans.isBranch) begin
                            bitValid = 1'b1;
                            bitVal   = trans.bitVal;
                        end
                    end else begin
                        err_d       = 1'b1;
                        if (errCount_q != CNT_MAX) begin
                            errCount_d = errCount_q + CNT_W'(1);
                        end
                        state_d     = HUNT;
                        lockCnt_d   = '0;
                        deserClear  = 1'b1;
                        prevCode_d  = s_in;
                        prevValid_d = curLegal;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State and tracking registers; reset overrides every other event
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            prevCode_q  <= C0;
            prevValid_q <= 1'b0;
            lockCnt_q   <= '0;
            err_q       <= 1'b0;
            errCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            prevCode_q  <= prevCode_d;
            prevValid_q <= prevValid_d;
            lockCnt_q   <= lockCnt_d;
            err_q       <= err_d;
            errCount_q  <= errCount_d;
        end
    end

    seq_deser #(
        .WORD_W (WORD_W)
    ) u_deser (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (deserClear),
        .bitValid_i  (bitValid),
        .bit_i       (bitVal),
        .aOut_o      (a_out),
        .aValid_o    (a_valid),
        .wordOut_o   (word_out),
        .wordValid_o (word_valid)
    );

    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign err_count = errCount_q;

endmodule

// File: tb/tb_seq_stream_decoder.sv
// Directed bench for seq_stream_decoder: lock-up, bit recovery, word packing,
// illegal codes/transitions, s_valid gaps, mid-word reset, counter saturation.
module tb_seq_stream_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0;
    logic [2:0] s_in = 3'd0;
    logic       locked;
    logic       a_out;
    logic       a_valid;
    logic [7:0] word_out;
    logic       word_valid;
    logic       err;
    logic [2:0] err_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Small counter width so saturation is reachable quickly
    seq_stream_decoder #(
        .WORD_W (8),
        .LOCK_N (4),
        .CNT_W  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_in       (s_in),
        .locked     (locked),
        .a_out      (a_out),
        .a_valid    (a_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .err        (err),
        .err_count  (err_count)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Drive one beat on the falling edge, then settle just after the rising edge
    task automatic applyStimulus(input logic rst, input logic v, input logic [2:0] code);
        @(negedge clk);
        reset   = rst;
        s_valid = v;
        s_in    = code;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string tag, input string field,
                            input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    // Compare every output with the hand-computed expectation; a_out only
    // carries meaning on an a_valid pulse
    task automatic checkOutput(input string tag, input logic expL, input logic expAv,
                               input logic expA, input logic expWv, input logic [7:0] expWord,
                               input logic expErr, input logic [2:0] expCnt);
        checkOne(tag, "locked", {7'd0, locked}, {7'd0, expL});
        checkOne(tag, "a_valid", {7'd0, a_valid}, {7'd0, expAv});
        if (expAv) checkOne(tag, "a_out", {7'd0, a_out}, {7'd0, expA});
        checkOne(tag, "word_valid", {7'd0, word_valid}, {7'd0, expWv});
        checkOne(tag, "word_out", word_out, expWord);
        checkOne(tag, "err", {7'd0, err}, {7'd0, expErr});
        checkOne(tag, "err_count", {5'd0, err_count}, {5'd0, expCnt});
    endtask

    task automatic feed(input string tag, input logic [2:0] code, input logic expL,
                        input logic expAv, input logic expA, input logic expWv,
                        input logic [7:0] expWord, input logic expErr, input logic [2:0] expCnt);
        applyStimulus(1'b0, 1'b1, code);
        checkOutput(tag, expL, expAv, expA, expWv, expWord, expErr, expCnt);
    endtask

    task automatic gap(input string tag, input logic [2:0] junk, input logic expL,
                       input logic [7:0] expWord, input logic [2:0] expCnt);
        applyStimulus(1'b0, 1'b0, junk);
        checkOutput(tag, expL, 1'b0, 1'b0, 1'b0, expWord, 1'b0, expCnt);
    endtask

    // Emits bits 1,0,1,1,0,0,1,0 starting from code 3 (word 8'h4D)
    task automatic word4D(input string tag, input logic [7:0] priorWord, input logic [2:0] cnt);
        feed(tag, 3'd5, 1, 1, 1, 0, priorWord, 0, cnt);
        feed(tag, 3'd2, 1, 0, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd4, 1, 0, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd0, 1, 1, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd3, 1, 0, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd5, 1, 1, 1, 0, priorWord, 0, cnt);
        feed(tag, 3'd2, 1, 0, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd4, 1, 0, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd3, 1, 1, 1, 0, priorWord, 0, cnt);
        feed(tag, 3'd2, 1, 1, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd4, 1, 0, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd0, 1, 1, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd3, 1, 0, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd5, 1, 1, 1, 0, priorWord, 0, cnt);
        feed(tag, 3'd2, 1, 0, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd4, 1, 0, 0, 0, priorWord, 0, cnt);
        feed(tag, 3'd0, 1, 1, 0, 1, 8'h4D, 0, cnt);
    endtask

    // Directed sequence
    initial begin
        logic [2:0] expCnt;

        // Reset held two cycles with live-looking input
        applyStimulus(1'b1, 1'b1, 3'd3);
        applyStimulus(1'b1, 1'b1, 3'd3);
        checkOutput("reset", 0, 0, 0, 0, 8'h00, 0, 3'd0);

        // Lock-up: 0,3,2,4,0 gives four legal transitions
        feed("lock", 3'd0, 0, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("lock", 3'd3, 0, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("lock", 3'd2, 0, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("lock", 3'd4, 0, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("lock", 3'd0, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("lock", 3'd3, 1, 0, 0, 0, 8'h00, 0, 3'd0);

        // Bit recovery: bits 1,1,0,0
        feed("bits", 3'd5, 1, 1, 1, 0, 8'h00, 0, 3'd0);
        feed("bits", 3'd2, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("bits", 3'd4, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("bits", 3'd3, 1, 1, 1, 0, 8'h00, 0, 3'd0);
        feed("bits", 3'd2, 1, 1, 0, 0, 8'h00, 0, 3'd0);
        feed("bits", 3'd4, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("bits", 3'd0, 1, 1, 0, 0, 8'h00, 0, 3'd0);

        // Finish the first word with bits 1,0,0,1 -> 8'h93
        feed("word1", 3'd3, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("word1", 3'd5, 1, 1, 1, 0, 8'h00, 0, 3'd0);
        feed("word1", 3'd2, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("word1", 3'd4, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("word1", 3'd0, 1, 1, 0, 0, 8'h00, 0, 3'd0);
        feed("word1", 3'd3, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("word1", 3'd2, 1, 1, 0, 0, 8'h00, 0, 3'd0);
        feed("word1", 3'd4, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("word1", 3'd3, 1, 1, 1, 1, 8'h93, 0, 3'd0);

        // Second word 8'h4D
        word4D("word2", 8'h93, 3'd0);

        // Illegal transition 0->2, then 2->4,4->0,0->3,3->5 relock
        feed("badtr", 3'd2, 0, 0, 0, 0, 8'h4D, 1, 3'd1);
        feed("badtr", 3'd4, 0, 0, 0, 0, 8'h4D, 0, 3'd1);
        feed("badtr", 3'd0, 0, 0, 0, 0, 8'h4D, 0, 3'd1);
        feed("badtr", 3'd3, 0, 0, 0, 0, 8'h4D, 0, 3'd1);
        feed("badtr", 3'd5, 1, 0, 0, 0, 8'h4D, 0, 3'd1);

        // Illegal code 7, then a fresh start plus four legal transitions
        feed("badcode", 3'd7, 0, 0, 0, 0, 8'h4D, 1, 3'd2);
        feed("badcode", 3'd2, 0, 0, 0, 0, 8'h4D, 0, 3'd2);
        feed("badcode", 3'd4, 0, 0, 0, 0, 8'h4D, 0, 3'd2);
        feed("badcode", 3'd3, 0, 0, 0, 0, 8'h4D, 0, 3'd2);
        feed("badcode", 3'd2, 0, 0, 0, 0, 8'h4D, 0, 3'd2);
        feed("badcode", 3'd4, 1, 0, 0, 0, 8'h4D, 0, 3'd2);

        // Bits with s_valid gaps carrying garbage codes
        feed("gaps", 3'd3, 1, 1, 1, 0, 8'h4D, 0, 3'd2);
        gap("gaps", 3'd7, 1, 8'h4D, 3'd2);
        feed("gaps", 3'd5, 1, 1, 1, 0, 8'h4D, 0, 3'd2);
        gap("gaps", 3'd1, 1, 8'h4D, 3'd2);
        feed("gaps", 3'd2, 1, 0, 0, 0, 8'h4D, 0, 3'd2);
        feed("gaps", 3'd4, 1, 0, 0, 0, 8'h4D, 0, 3'd2);
        gap("gaps", 3'd6, 1, 8'h4D, 3'd2);
        feed("gaps", 3'd0, 1, 1, 0, 0, 8'h4D, 0, 3'd2);

        // Reset mid-word clears everything including err_count
        applyStimulus(1'b1, 1'b1, 3'd3);
        checkOutput("midrst", 0, 0, 0, 0, 8'h00, 0, 3'd0);

        // Relock; the next word must start at bit 0
        feed("relock", 3'd0, 0, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("relock", 3'd3, 0, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("relock", 3'd2, 0, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("relock", 3'd4, 0, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("relock", 3'd0, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        feed("relock", 3'd3, 1, 0, 0, 0, 8'h00, 0, 3'd0);
        word4D("word3", 8'h00, 3'd0);

        // Repeated errors: counter stops at 7
        expCnt = 3'd0;
        for (int i = 0; i < 9; i++) begin
            if (expCnt != 3'd7) expCnt = expCnt + 3'd1;
            feed("sat", 3'd7, 0, 0, 0, 0, 8'h4D, 1, expCnt);
            feed("sat", 3'd0, 0, 0, 0, 0, 8'h4D, 0, expCnt);
            feed("sat", 3'd3, 0, 0, 0, 0, 8'h4D, 0, expCnt);
            feed("sat", 3'd2, 0, 0, 0, 0, 8'h4D, 0, expCnt);
            feed("sat", 3'd4, 0, 0, 0, 0, 8'h4D, 0, expCnt);
            feed("sat", 3'd0, 1, 0, 0, 0, 8'h4D, 0, expCnt);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
